// File: rtl/mem_access.sv
// mem_access: MEM stage with a byte-serial little-endian RAM port.
// It stalls the pipe until a load or store completes, then sign- or zero-extends the load data.
// Ports: ex_* come from ex_mem, and mem_wd/mem_wreg/mem_wdata go to mem_wb.
// stallreq_mem goes to the stall controller, and mem_a/mem_dout/mem_wr/mem_din form the RAM port.
// Optional MEM_MISALIGN_CHECK_EN: misaligned H/W accesses are flagged and skipped.
module mem_access #(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall_state,
  input  logic [4:0]        ex_wd,
  input  logic              ex_wreg,
  input  logic [31:0]       ex_wdata,
  input  logic              ex_mem_ld,
  input  logic              ex_mem_st,
  input  logic [2:0]        ex_funct3,
  input  logic [ADDR_W-1:0] ex_mem_addr,
  input  logic [31:0]       ex_mem_sdata,
  output logic [4:0]        mem_wd,
  output logic              mem_wreg,
  output logic [31:0]       mem_wdata,
  output logic              stallreq_mem,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  input  logic [7:0]        mem_din,
  output logic              misalign_err
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_t;

  state_t            state, state_nx;
  logic [2:0]        cnt, cnt_nx;
  logic [31:0]       asm_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       sdata_q;
  logic [2:0]        f3_q;
  logic [4:0]        wd_q;
  logic              wreg_q;
  logic              ld_q;
  logic              mis_q;
  logic              err_q;
  logic [2:0]        n_q;
  logic [2:0]        n_in;
  logic              start;
  logic              mis;
  logic              cap;
  logic [2:0]        lane;
  logic [2:0]        last_rd;
  logic              sx;
  logic [31:0]       ext;
  logic              unused_bits;

  assign unused_bits = ^{stall_state[5:4], stall_state[2:0]};

  // funct3 011 and 11x fall into the word case
  assign n_in = ex_funct3[1] ? 3'd4
              : (ex_funct3[0] ? 3'd2 : 3'd1);

`ifdef MEM_MISALIGN_CHECK_EN
  assign mis = ex_funct3[1] ? (ex_mem_addr[1:0] != 2'b00)
             : (ex_funct3[0] & ex_mem_addr[0]);
`else
  assign mis = 1'b0;
`endif

  // read data trails the issued address by RD_LAT cycles
  assign lane    = cnt - 3'(RD_LAT);
  assign cap     = (state == RD) && (cnt >= 3'(RD_LAT));
  assign last_rd = n_q + 3'(RD_LAT) - 3'd1;

  assign sx = ~f3_q[2];

  always_comb begin
    ext = asm_q;
    unique case (1'b1)
      f3_q[1]: ext = asm_q;
      (f3_q[1:0] == 2'b01):
        ext = {{16{sx & asm_q[15]}}, asm_q[15:0]};
      default:
        ext = {{24{sx & asm_q[7]}}, asm_q[7:0]};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      asm_q   <= '0;
      addr_q  <= '0;
      sdata_q <= '0;
      f3_q    <= '0;
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      ld_q    <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      n_q     <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      err_q <= start & mis;
      if (start) begin
        addr_q  <= ex_mem_addr;
        sdata_q <= ex_mem_sdata;
        f3_q    <= ex_funct3;
        wd_q    <= ex_wd;
        wreg_q  <= ex_wreg;
        ld_q    <= ex_mem_ld;
        mis_q   <= mis;
        n_q     <= n_in;
        asm_q   <= '0;
      end else if (cap) begin
        asm_q[{lane[1:0], 3'b000} +: 8] <= mem_din;
      end
    end
  end

  // outputs are forced to 0 while rst is low, even in IDLE pass-through
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    start        = 1'b0;
    mem_wd       = '0;
    mem_wreg     = 1'b0;
    mem_wdata    = '0;
    stallreq_mem = 1'b0;
    mem_a        = '0;
    mem_dout     = '0;
    mem_wr       = 1'b0;
    misalign_err = 1'b0;
    if (rst) begin
      unique case (state)
        IDLE: begin
          if (ex_mem_ld | ex_mem_st) begin
            stallreq_mem = 1'b1;
            start        = 1'b1;
            cnt_nx       = '0;
            if (mis)
              state_nx = DONE;
            else if (ex_mem_ld)
              state_nx = RD;
            else
              state_nx = WR;
          end else begin
            mem_wd    = ex_wd;
            mem_wreg  = ex_wreg;
            mem_wdata = ex_wdata;
          end
        end
        WR: begin
          stallreq_mem = 1'b1;
          mem_wr       = 1'b1;
          mem_a        = addr_q + ADDR_W'(cnt);
          mem_dout     = sdata_q[{cnt[1:0], 3'b000} +: 8];
          cnt_nx       = cnt + 3'd1;
          if (cnt == n_q - 3'd1) begin
            state_nx = DONE;
            cnt_nx   = '0;
          end
        end
        RD: begin
          stallreq_mem = 1'b1;
          if (cnt < n_q)
            mem_a = addr_q + ADDR_W'(cnt);
          cnt_nx = cnt + 3'd1;
          if (cnt == last_rd) begin
            state_nx = DONE;
            cnt_nx   = '0;
          end
        end
        DONE: begin
          mem_wd       = wd_q;
          mem_wreg     = wreg_q & ld_q & ~mis_q;
          mem_wdata    = (ld_q & ~mis_q) ? ext : '0;
          misalign_err = err_q;
          if (!stall_state[3])
            state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: random and directed ops against a transaction-level model.
// The model covers the RAM bus sequence and the extended load results.
module tb_mem_access;
  localparam int AW = 32;
  localparam int RL = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_state;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic        ex_mem_ld;
  logic        ex_mem_st;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_mem_sdata;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        stallreq_mem;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        misalign_err;

  int total = 0;
  int bad   = 0;
  int scnt  = 0;

  always #5 clk = ~clk;

  mem_access #(.ADDR_W(AW), .RD_LAT(RL)) dut (
    .clk(clk), .rst(rst), .stall_state(stall_state),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_mem_ld(ex_mem_ld), .ex_mem_st(ex_mem_st),
    .ex_funct3(ex_funct3), .ex_mem_addr(ex_mem_addr),
    .ex_mem_sdata(ex_mem_sdata), .mem_wd(mem_wd),
    .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .stallreq_mem(stallreq_mem), .mem_a(mem_a),
    .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
    .misalign_err(misalign_err)
  );

  // RAM environment and model shadow memory
  logic [7:0]  ram    [logic [31:0]];
  logic [7:0]  shadow [logic [31:0]];
  logic [7:0]  rpipe  [RL] = '{default: 8'h00};
  logic [31:0] bus_a  = '0;
  logic        bus_wr = 1'b0;
  logic [7:0]  bus_d  = '0;

  function automatic logic [7:0] seed_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : seed_byte(a);
  endfunction

  function automatic logic [7:0] sh_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : seed_byte(a);
  endfunction

  always @(negedge clk) begin
    bus_a  <= mem_a;
    bus_wr <= mem_wr;
    bus_d  <= mem_dout;
    if (stallreq_mem) scnt++;
  end

  always @(posedge clk) begin
    if (bus_wr) ram[bus_a] = bus_d;
    rpipe[0] <= ram_rd(bus_a);
    for (int k = 1; k < RL; k++) rpipe[k] <= rpipe[k-1];
  end
  assign mem_din = rpipe[RL-1];

  // expected outputs for the current cycle
  logic        chk = 1'b0;
  logic [4:0]  e_wd;
  logic        e_wreg;
  logic [31:0] e_wdata;
  logic        c_w;
  logic        e_stall;
  logic        e_wr;
  logic        e_err;
  logic        c_a;
  logic [31:0] e_a;
  logic        c_d;
  logic [7:0]  e_d;
  logic        ok;

  always @(negedge clk) begin
    if (chk) begin
      total++;
      ok = (mem_wd === e_wd) && (mem_wreg === e_wreg)
        && (stallreq_mem === e_stall) && (mem_wr === e_wr)
        && (misalign_err === e_err)
        && (!c_w || mem_wdata === e_wdata)
        && (!c_a || mem_a === e_a)
        && (!c_d || mem_dout === e_d);
      if (!ok) begin
        bad++;
        $display("FAIL cycle @%0t got wd=%h wreg=%b wdata=%h stall=%b wr=%b err=%b a=%h d=%h need wd=%h wreg=%b wdata=%h(%b) stall=%b wr=%b err=%b a=%h(%b) d=%h(%b)",
          $time, mem_wd, mem_wreg, mem_wdata, stallreq_mem, mem_wr,
          misalign_err, mem_a, mem_dout, e_wd, e_wreg, e_wdata, c_w,
          e_stall, e_wr, e_err, e_a, c_a, e_d, c_d);
      end
    end
  end

  task automatic lit(input string nm, input logic [127:0] got,
                     input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic set_exp(input logic [4:0] wd, input logic wreg,
      input logic [31:0] wdata, input logic cw, input logic stl,
      input logic wr, input logic err, input logic ca,
      input logic [31:0] a, input logic cd, input logic [7:0] d);
    chk = 1'b1; e_wd = wd; e_wreg = wreg; e_wdata = wdata; c_w = cw;
    e_stall = stl; e_wr = wr; e_err = err; c_a = ca; e_a = a;
    c_d = cd; e_d = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] ss(input bit b3);
    logic [5:0] r;
    r = 6'($urandom);
    r[3] = b3;
    return r;
  endfunction

  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
      input logic [31:0] addr, input logic [31:0] sd,
      input logic [4:0] wd, input bit wreg, input logic [31:0] wdata,
      input int hold, input bit lit_en, input logic [31:0] lit_w);
    int n;
    bit mis;
    bit sgn;
    logic [31:0] v;
    case (f3)
      3'b000, 3'b100: n = 1;
      3'b001, 3'b101: n = 2;
      default:        n = 4;
    endcase
    sgn = (f3 == 3'b000) || (f3 == 3'b001);
    mis = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    mis = (n == 4) ? (addr % 4 != 0) : ((n == 2) && (addr % 2 != 0));
`endif
    ex_mem_ld = ld; ex_mem_st = st; ex_funct3 = f3;
    ex_mem_addr = addr; ex_mem_sdata = sd; ex_wd = wd;
    ex_wreg = wreg; ex_wdata = wdata;
    if (!ld && !st) begin
      stall_state = ss(1'b0);
      set_exp(wd, wreg, wdata, 1, 0, 0, 0, 0, 0, 0, 0);
      if (lit_en) begin
        #1;
        lit("alu_wdata", mem_wdata, lit_w);
        lit("alu_wd", mem_wd, wd);
      end
      step();
      return;
    end
    stall_state = ss(1'b1);
    set_exp(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    step();
    if (!mis && st) begin
      for (int k = 0; k < n; k++) begin
        set_exp(0, 0, 0, 1, 1, 1, 0, 1, addr + 32'(k), 1, sd[8*k +: 8]);
        shadow[addr + 32'(k)] = sd[8*k +: 8];
        step();
      end
    end else if (!mis) begin
      for (int k = 0; k < n + RL; k++) begin
        set_exp(0, 0, 0, 1, 1, 0, 0, k < n, addr + 32'(k), 0, 0);
        step();
      end
    end
    v = '0;
    for (int k = 0; k < n; k++)
      v = v | (32'(sh_rd(addr + 32'(k))) << (8 * k));
    if (n < 4 && sgn && v[8*n-1])
      v = v | ~((32'd1 << (8 * n)) - 32'd1);
    if (!ld) v = '0;
    for (int h = 0; h <= hold; h++) begin
      stall_state = ss(h < hold);
      set_exp(wd, ld && !mis && wreg, v, !mis, 0, 0, mis && h == 0,
              0, 0, 0, 0);
      if (lit_en && h == 0) begin
        #1;
        lit("done_wdata", mem_wdata, lit_w);
      end
      step();
    end
  endtask

  task automatic reset_mid_sw();
    ex_mem_ld = 0; ex_mem_st = 1; ex_funct3 = 3'b010;
    ex_mem_addr = 32'h300; ex_mem_sdata = 32'hCAFEF00D;
    ex_wd = 5'd9; ex_wreg = 1; ex_wdata = 32'h77;
    stall_state = ss(1'b1);
    set_exp(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    step();
    set_exp(0, 0, 0, 1, 1, 1, 0, 1, 32'h300, 1, 8'h0D);
    shadow[32'h300] = 8'h0D;
    step();
    chk = 1'b0;
    rst = 1'b0;
    #1;
    lit("rst_async_outs",
        {mem_wd, mem_wreg, mem_wdata, stallreq_mem, mem_a,
         mem_dout, mem_wr, misalign_err}, '0);
    ex_mem_st = 0;
    ex_wd = 5'd3; ex_wdata = 32'h55AA;
    step();
    step();
    rst = 1'b1;
    run_op(0, 0, 0, 0, 0, 5'd3, 1, 32'h55AA, 0, 1, 32'h55AA);
  endtask

  initial begin
    rst = 1'b0;
    ex_wd = 5'd7; ex_wreg = 1; ex_wdata = 32'h1111;
    ex_mem_ld = 0; ex_mem_st = 0; ex_funct3 = 0;
    ex_mem_addr = 0; ex_mem_sdata = 0; stall_state = 0;
    repeat (2) @(posedge clk);
    #1;
    lit("reset_outs",
        {mem_wd, mem_wreg, mem_wdata, stallreq_mem, mem_a,
         mem_dout, mem_wr, misalign_err}, '0);
    rst = 1'b1;

    run_op(0, 0, 0, 0, 0, 5'd5, 1, 32'h1234, 0, 1, 32'h1234);

    scnt = 0;
    run_op(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd4, 1, 0, 0, 0, 0);
    lit("sw_stall_cycles", scnt, 5);

    ram[32'h200] = 8'h80;
    shadow[32'h200] = 8'h80;
    scnt = 0;
    run_op(1, 0, 3'b000, 32'h200, 0, 5'd6, 1, 0, 0, 1, 32'hFFFFFF80);
    lit("lb_stall_cycles", scnt, 3);
    scnt = 0;
    run_op(1, 0, 3'b100, 32'h200, 0, 5'd6, 1, 0, 0, 1, 32'h00000080);
    lit("lbu_stall_cycles", scnt, 3);

    scnt = 0;
    run_op(1, 0, 3'b010, 32'hFFFFFFFE, 0, 5'd7, 1, 0, 0, 0, 0);
`ifdef MEM_MISALIGN_CHECK_EN
    lit("lw_wrap_stall_cycles", scnt, 1);
`else
    lit("lw_wrap_stall_cycles", scnt, 6);
`endif

    ram[32'h10] = 8'h34; ram[32'h11] = 8'h12;
    shadow[32'h10] = 8'h34; shadow[32'h11] = 8'h12;
    scnt = 0;
    run_op(1, 0, 3'b001, 32'h10, 0, 5'd8, 1, 0, 3, 1, 32'h00001234);
    lit("lh_hold_stall_cycles", scnt, 4);

    reset_mid_sw();
    run_op(1, 0, 3'b100, 32'h301, 0, 5'd2, 1, 0, 0, 1,
           32'(seed_byte(32'h301)));
    run_op(1, 0, 3'b100, 32'h300, 0, 5'd2, 1, 0, 0, 1, 32'h0000000D);

    for (int i = 0; i < 400; i++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      if ($urandom_range(0, 9) == 0)
        a = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
      else
        a = 32'h400 + 32'($urandom_range(0, 63));
      run_op(kind == 1, kind == 2, 3'($urandom), a, $urandom,
             5'($urandom), 1'($urandom), $urandom,
             $urandom_range(0, 3), 0, 0);
    end

    chk = 1'b0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
